// File: rtl/id_ex_pkg.sv
// Shared widths and Tuse/Tnew encodings for the decode-to-execute boundary.
package id_ex_pkg;
    localparam int WIDTH = 32;
    localparam int TW    = 2;

    localparam logic [TW-1:0] T0 = 2'd0;
    localparam logic [TW-1:0] T1 = 2'd1;
    localparam logic [TW-1:0] T2 = 2'd2;
    localparam logic [TW-1:0] T3 = 2'd3;

    // A source with this Tuse is never read, so it can never lose a compare.
    localparam logic [TW-1:0] TUSE_NONE = T3;

    localparam logic [WIDTH-1:0] NOP = 32'h0;
endpackage

// File: rtl/id_ex_stall_ctrl.sv
// Tuse/Tnew hazard compare between the D-stage sources and the E/M destinations.
module stall_ctrl
    import id_ex_pkg::*;
#(
    parameter int STW = id_ex_pkg::TW
) (
    input  logic [4:0]     rs_D,
    input  logic [4:0]     rt_D,
    input  logic [STW-1:0] tuse_rs_D,
    input  logic [STW-1:0] tuse_rt_D,
    input  logic [4:0]     wa_E,
    input  logic [STW-1:0] tnew_E,
    input  logic [4:0]     wa_M,
    input  logic [STW-1:0] tnew_M,
    output logic           D_stall
);
    logic stall_rs_E;
    logic stall_rs_M;
    logic stall_rt_E;
    logic stall_rt_M;

    // Register 0 is hardwired, so a match on it is never a real dependency.
    assign stall_rs_E = (rs_D != 5'd0) && (rs_D == wa_E) && (tuse_rs_D < tnew_E);
    assign stall_rs_M = (rs_D != 5'd0) && (rs_D == wa_M) && (tuse_rs_D < tnew_M);
    assign stall_rt_E = (rt_D != 5'd0) && (rt_D == wa_E) && (tuse_rt_D < tnew_E);
    assign stall_rt_M = (rt_D != 5'd0) && (rt_D == wa_M) && (tuse_rt_D < tnew_M);

    assign D_stall = stall_rs_E | stall_rs_M | stall_rt_E | stall_rt_M;
endmodule

// File: rtl/id_ex.sv
// D-to-E pipeline register with bubble insertion on a Tuse/Tnew hazard.
module id_ex #(
    parameter int WIDTH = id_ex_pkg::WIDTH,
    parameter int TW    = id_ex_pkg::TW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_D,
    input  logic [WIDTH-1:0] instr_D,
    input  logic [WIDTH-1:0] rs_data_D,
    input  logic [WIDTH-1:0] rt_data_D,
    input  logic [WIDTH-1:0] imm_D,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       wa_D,
    input  logic [TW-1:0]    tuse_rs_D,
    input  logic [TW-1:0]    tuse_rt_D,
    input  logic [TW-1:0]    tnew_D,
    input  logic [4:0]       wa_M,
    input  logic [TW-1:0]    tnew_M,
    output logic             D_stall,
    output logic [WIDTH-1:0] pc_E,
    output logic [WIDTH-1:0] instr_E,
    output logic [WIDTH-1:0] rs_data_E,
    output logic [WIDTH-1:0] rt_data_E,
    output logic [WIDTH-1:0] imm_E,
    output logic [4:0]       wa_E,
    output logic [TW-1:0]    tnew_E,
    output logic [TW-1:0]    tnew_EM,
    output logic             valid_E,
    output logic [15:0]      bubble_cnt
);
    import id_ex_pkg::*;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    stall_ctrl #(.STW(TW)) u_stall_ctrl (
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .wa_E      (wa_E),
        .tnew_E    (tnew_E),
        .wa_M      (wa_M),
        .tnew_M    (tnew_M),
        .D_stall   (D_stall)
    );

    assign tnew_EM = sat_dec(tnew_E);

    // E stage: a stall turns the slot into a bubble but keeps pc for debug.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_E       <= '0;
            instr_E    <= '0;
            rs_data_E  <= '0;
            rt_data_E  <= '0;
            imm_E      <= '0;
            wa_E       <= '0;
            tnew_E     <= '0;
            valid_E    <= 1'b0;
            bubble_cnt <= '0;
        end else if (D_stall) begin
            pc_E       <= pc_D;
            instr_E    <= WIDTH'(NOP);
            rs_data_E  <= '0;
            rt_data_E  <= '0;
            imm_E      <= '0;
            wa_E       <= '0;
            tnew_E     <= TW'(T0);
            valid_E    <= 1'b0;
            bubble_cnt <= sat_inc(bubble_cnt);
        end else begin
            pc_E       <= pc_D;
            instr_E    <= instr_D;
            rs_data_E  <= rs_data_D;
            rt_data_E  <= rt_data_D;
            imm_E      <= imm_D;
            wa_E       <= wa_D;
            tnew_E     <= tnew_D;
            valid_E    <= 1'b1;
        end
    end
endmodule
